fault_capture_latch: RTL and testbench

Per-rail fault qualifier and sticky latch that feeds the fault vector consumed by the fault-to-code converter in the power-sequencing core. Each monitored rail's power-good is qualified by its enable, filtered over a programmable number of sample ticks, and latched as a sticky fault bit. The block also records which rail faulted first and counts the latched faults for BMC/LED reporting. Bits above NUM_RAILS on the output vector are tied to 0.

---
 rtl/fault_capture_latch_pkg.sv | 29 ++
 rtl/fault_rail_filter.sv | 48 ++++
 rtl/fault_capture_latch.sv | 97 +++++++++
 tb/tb_fault_capture_latch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fault_capture_latch_pkg.sv
// Shared widths and rail-index map for the power-sequencing fault path.
// Index order matches the fault-stage ordering used by the code converter.
package fault_capture_latch_pkg;

  localparam int FAULT_VEC_W = 255;
  localparam int IDX_W       = 8;
  localparam int CNT_W       = 4;

  localparam int RAIL_BMC        = 0;
  localparam int RAIL_PCH_P1V8   = 1;
  localparam int RAIL_PCH_P1V05  = 2;
  localparam int RAIL_PSU        = 3;
  localparam int RAIL_MAIN_VR    = 4;
  localparam int RAIL_VDDQ_0     = 5;
  localparam int RAIL_VDDQ_1     = 6;
  localparam int RAIL_VDDQ_2     = 7;
  localparam int RAIL_VDDQ_3     = 8;
  localparam int RAIL_CPU1_VCCIN = 9;
  localparam int RAIL_CPU1_VCCSA = 10;
  localparam int RAIL_CPU1_VCCIO = 11;
  localparam int RAIL_CPU1_VCCAN = 12;
  localparam int RAIL_CPU1_VDDQ  = 13;
  localparam int RAIL_CPU2_VCCIN = 14;
  localparam int RAIL_CPU2_VCCSA = 15;
  localparam int RAIL_CPU2_VCCAN = 16;
  localparam int RAIL_CPU2_VDDQ  = 17;
  localparam int RAIL_CPU2_VCCIO = 18;

endpackage

// File: rtl/fault_rail_filter.sv
// One rail: saturating bad-sample counter plus sticky fault bit.
// oSet flags the cycle this rail newly latches (already masked by clear).
module fault_rail_filter
  import fault_capture_latch_pkg::*;
#(
  parameter int FILT_CNT = 3
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  input  logic iCE,
  input  logic iBad,
  output logic oSet,
  output logic oFault
);

  localparam logic [CNT_W-1:0] LP_FILT = CNT_W'(FILT_CNT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fault;
  logic             w_reach;

  always_comb begin
    w_cnt_nxt = '0;
    if (iBad) begin
      w_cnt_nxt = (r_cnt >= LP_FILT) ? LP_FILT : r_cnt + 1'b1;
    end
  end

  assign w_reach = iCE & iBad & ~r_fault
                 & (w_cnt_nxt == LP_FILT);
  assign oSet    = w_reach & ~iClr;
  assign oFault  = r_fault;

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else if (iCE) begin
      r_cnt <= w_cnt_nxt;
      if (w_reach) begin
        r_fault <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_capture_latch.sv
// Per-rail fault qualifier with sticky vector, first-fault record
// and registered fault count for BMC/LED reporting.
module fault_capture_latch
  import fault_capture_latch_pkg::*;
#(
  parameter int NUM_RAILS = 19,
  parameter int FILT_CNT  = 3
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [NUM_RAILS-1:0]   iPwrgd,
  input  logic [NUM_RAILS-1:0]   iRailEn,
  input  logic                   iSampleCE,
  input  logic                   iClrFault,
  output logic [FAULT_VEC_W-1:0] oFaultVec,
  output logic                   oAnyFault,
  output logic                   oFaultEvent,
  output logic                   oFirstValid,
  output logic [IDX_W-1:0]       oFirstIdx,
  output logic [IDX_W-1:0]       oFaultCnt
);

  logic [NUM_RAILS-1:0] w_bad;
  logic [NUM_RAILS-1:0] w_set;
  logic [NUM_RAILS-1:0] w_fault;
  logic [IDX_W-1:0]     w_first_idx;
  logic [IDX_W-1:0]     w_pop;

  logic                 r_event;
  logic                 r_first_valid;
  logic [IDX_W-1:0]     r_first_idx;
  logic [IDX_W-1:0]     r_cnt;

  assign w_bad = iRailEn & ~iPwrgd;

  for (genvar g = 0; g < NUM_RAILS; g++) begin : g_rail
    fault_rail_filter #(
      .FILT_CNT (FILT_CNT)
    ) u_filt (
      .iClk   (iClk),
      .iRst   (iRst),
      .iClr   (iClrFault),
      .iCE    (iSampleCE),
      .iBad   (w_bad[g]),
      .oSet   (w_set[g]),
      .oFault (w_fault[g])
    );
  end

  // Scan downward so the lowest setting index wins.
  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (w_set[i]) begin
        w_first_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      w_pop = w_pop + IDX_W'(w_fault[i]);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_event       <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_cnt         <= '0;
    end else begin
      r_event <= |w_set;
      r_cnt   <= w_pop;
      if (iClrFault) begin
        r_first_valid <= 1'b0;
        r_first_idx   <= '0;
      end else if (!r_first_valid && |w_set) begin
        r_first_valid <= 1'b1;
        r_first_idx   <= w_first_idx;
      end
    end
  end

  always_comb begin
    oFaultVec                = '0;
    oFaultVec[NUM_RAILS-1:0] = w_fault;
  end

  assign oAnyFault   = |w_fault;
  assign oFaultEvent = r_event;
  assign oFirstValid = r_first_valid;
  assign oFirstIdx   = r_first_idx;
  assign oFaultCnt   = r_cnt;

endmodule

// File: tb/tb_fault_capture_latch.sv
// Scoreboard bench: stimulus queues per-edge expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_fault_capture_latch;
  import fault_capture_latch_pkg::*;

  localparam int NR = 19;

  logic                   iClk = 1'b0;
  logic                   iRst;
  logic [NR-1:0]          iPwrgd;
  logic [NR-1:0]          iRailEn;
  logic                   iSampleCE;
  logic                   iClrFault;
  logic [FAULT_VEC_W-1:0] oFaultVec;
  logic                   oAnyFault;
  logic                   oFaultEvent;
  logic                   oFirstValid;
  logic [IDX_W-1:0]       oFirstIdx;
  logic [IDX_W-1:0]       oFaultCnt;

  fault_capture_latch #(
    .NUM_RAILS (NR),
    .FILT_CNT  (3)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iPwrgd      (iPwrgd),
    .iRailEn     (iRailEn),
    .iSampleCE   (iSampleCE),
    .iClrFault   (iClrFault),
    .oFaultVec   (oFaultVec),
    .oAnyFault   (oAnyFault),
    .oFaultEvent (oFaultEvent),
    .oFirstValid (oFirstValid),
    .oFirstIdx   (oFirstIdx),
    .oFaultCnt   (oFaultCnt)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          at;
    string       name;
    logic [NR-1:0] vec;
    logic        ev;
    logic        fv;
    logic [7:0]  idx;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pe  = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge iClk) n_pe <= n_pe + 1;

  // Monitor: outputs are registered, so they are stable at negedge.
  always @(negedge iClk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= n_pe) begin
      exp_t e;
      logic [FAULT_VEC_W-1:0] ev_full;
      e = exp_q.pop_front();
      n_vec++;
      ev_full = '0;
      ev_full[NR-1:0] = e.vec;
      if (e.at != n_pe) begin
        n_bad++;
        $display("FAIL %s: stale expectation at edge %0d (now %0d)",
                 e.name, e.at, n_pe);
      end else if (oFaultVec !== ev_full || oAnyFault !== (|e.vec) ||
                   oFaultEvent !== e.ev || oFirstValid !== e.fv ||
                   oFirstIdx !== e.idx || oFaultCnt !== e.cnt) begin
        n_bad++;
        $display({"FAIL %s: got vec=%h any=%b ev=%b fv=%b idx=%0d cnt=%0d",
                  " want vec=%h any=%b ev=%b fv=%b idx=%0d cnt=%0d"},
                 e.name, oFaultVec[NR-1:0], oAnyFault, oFaultEvent,
                 oFirstValid, oFirstIdx, oFaultCnt,
                 e.vec, |e.vec, e.ev, e.fv, e.idx, e.cnt);
        if (oFaultVec[FAULT_VEC_W-1:NR] !== '0)
          $display("FAIL %s: upper vector bits nonzero", e.name);
      end
    end
  end

  localparam logic [NR-1:0] ALL = '1;

  function automatic logic [NR-1:0] b(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic cy(input string nm,
                    input logic [NR-1:0] pg, input logic [NR-1:0] en,
                    input logic ce, input logic clr, input logic rst,
                    input logic [NR-1:0] e_vec, input logic e_ev,
                    input logic e_fv, input logic [7:0] e_idx,
                    input logic [7:0] e_cnt);
    exp_t e;
    iPwrgd    = pg;
    iRailEn   = en;
    iSampleCE = ce;
    iClrFault = clr;
    iRst      = rst;
    e.at   = n_pe + 1;
    e.name = nm;
    e.vec  = e_vec;
    e.ev   = e_ev;
    e.fv   = e_fv;
    e.idx  = e_idx;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
    @(negedge iClk);
  endtask

  initial begin
    logic [NR-1:0] v;
    int r6, r4, r12, r15, r2, r7, r10;
    r6  = RAIL_VDDQ_1;
    r4  = RAIL_MAIN_VR;
    r12 = RAIL_CPU1_VCCAN;
    r15 = RAIL_CPU2_VCCSA;
    r2  = RAIL_PCH_P1V05;
    r7  = RAIL_VDDQ_2;
    r10 = RAIL_CPU1_VCCSA;

    cy("reset", ALL, ALL, 0, 0, 1, '0, 0, 0, 0, 0);
    cy("idle", ALL, ALL, 1, 0, 0, '0, 0, 0, 0, 0);

    // Rail 6 latches on third bad CE
    cy("r6 ce1", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r6 ce2", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r6 nce", ALL & ~b(r6), ALL, 0, 0, 0, '0, 0, 0, 0, 0);
    cy("r6 ce3", ALL & ~b(r6), ALL, 1, 0, 0, b(r6), 1, 1, 6, 0);
    cy("r6 cnt", ALL, ALL, 0, 0, 0, b(r6), 0, 1, 6, 1);
    cy("r6 sticky", ALL, ALL & ~b(r6), 1, 0, 0, b(r6), 0, 1, 6, 1);
    cy("r6 clr", ALL, ALL, 0, 1, 0, '0, 0, 0, 0, 1);
    cy("r6 clr2", ALL, ALL, 0, 0, 0, '0, 0, 0, 0, 0);

    // Glitch never accumulates three in a row
    cy("gl 1", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("gl 2", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("gl ok", ALL, ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("gl 3", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("gl 4", ALL & ~b(r6), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("gl end", ALL, ALL, 1, 0, 0, '0, 0, 0, 0, 0);

    // Disabled rail is ignored
    for (int i = 0; i < 10; i++)
      cy("dis r10", ALL & ~b(r10), ALL & ~b(r10), 1, 0, 0,
         '0, 0, 0, 0, 0);

    // Rails 4 and 12 together, then rail 15 later
    v = ALL & ~b(r4) & ~b(r12);
    cy("dual 1", v, ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("dual 2", v, ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("dual 3", v, ALL, 1, 0, 0, b(r4) | b(r12), 1, 1, 4, 0);
    cy("dual cnt", ALL, ALL, 1, 0, 0, b(r4) | b(r12), 0, 1, 4, 2);
    v = b(r4) | b(r12) | b(r15);
    cy("r15 1", ALL & ~b(r15), ALL, 1, 0, 0, b(r4) | b(r12), 0, 1, 4, 2);
    cy("r15 2", ALL & ~b(r15), ALL, 1, 0, 0, b(r4) | b(r12), 0, 1, 4, 2);
    cy("r15 3", ALL & ~b(r15), ALL, 1, 0, 0, v, 1, 1, 4, 2);
    cy("r15 cnt", ALL, ALL, 0, 0, 0, v, 0, 1, 4, 3);
    cy("dual clr", ALL, ALL, 0, 1, 0, '0, 0, 0, 0, 3);
    cy("dual clr2", ALL, ALL, 0, 0, 0, '0, 0, 0, 0, 0);

    // Clear wins over a same-cycle latch; rail 2 re-latches
    cy("r2 1", ALL & ~b(r2), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r2 2", ALL & ~b(r2), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r2 clr", ALL & ~b(r2), ALL, 1, 1, 0, '0, 0, 0, 0, 0);
    cy("r2 re1", ALL & ~b(r2), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r2 re2", ALL & ~b(r2), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r2 re3", ALL & ~b(r2), ALL, 1, 0, 0, b(r2), 1, 1, 2, 0);
    cy("r2 cnt", ALL, ALL, 0, 0, 0, b(r2), 0, 1, 2, 1);

    // Reset mid-filter on rail 7 with rail 2 still latched
    cy("r7 1", ALL & ~b(r7), ALL, 1, 0, 0, b(r2), 0, 1, 2, 1);
    cy("r7 2", ALL & ~b(r7), ALL, 1, 0, 0, b(r2), 0, 1, 2, 1);
    cy("r7 rst", ALL & ~b(r7), ALL, 1, 0, 1, '0, 0, 0, 0, 0);
    cy("r7 a1", ALL & ~b(r7), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r7 a2", ALL & ~b(r7), ALL, 1, 0, 0, '0, 0, 0, 0, 0);
    cy("r7 a3", ALL & ~b(r7), ALL, 1, 0, 0, b(r7), 1, 1, 7, 0);
    cy("r7 cnt", ALL, ALL, 0, 0, 0, b(r7), 0, 1, 7, 1);

    iSampleCE = 0;
    iClrFault = 0;
    iRst      = 0;
    repeat (3) @(negedge iClk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
